// File: rtl/fifo_burst_framer.sv
// Drains a first-word-fall-through FIFO into a valid/ready stream, framing
// bursts of up to BURST_LEN beats with one word held back so last is known early.
module fifo_burst_framer #(
    parameter int DW        = 16,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 32,
    parameter int CW        = $clog2(BURST_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    output logic          fifo_rden,
    input  logic          flush,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_last,
    input  logic          m_ready,
    output logic [CW-1:0] beat_cnt,
    output logic          busy
);

    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] BEAT_MAX = CW'(BURST_LEN - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

    logic          hold_vld_q, hold_vld_d;
    logic [DW-1:0] hold_data_q, hold_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          flush_pend_q, flush_pend_d;

    logic adv, close, issue, pop;

    assign adv   = ~m_valid_q | m_ready;
    assign close = (beat_cnt_q == BEAT_MAX) | flush | flush_pend_q
                 | ((idle_cnt_q == IDLE_MAX) & fifo_empty);
    // A held word only leaves when its last flag is settled: either a successor
    // is visible in the FIFO or the burst is being closed.
    assign issue = hold_vld_q & adv & (~fifo_empty | close);
    assign pop   = rst_n & ~fifo_empty & (~hold_vld_q | issue);

    always_comb begin
        hold_vld_d   = hold_vld_q;
        hold_data_d  = hold_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;
        beat_cnt_d   = beat_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        flush_pend_d = flush_pend_q;

        if (issue) begin
            m_data_d   = hold_data_q;
            m_valid_d  = 1'b1;
            m_last_d   = close;
            hold_vld_d = 1'b0;
            beat_cnt_d = close ? '0 : beat_cnt_q + CW'(1);
        end else if (m_valid_q & m_ready) begin
            m_valid_d = 1'b0;
        end

        if (pop) begin
            hold_data_d = fifo_dout;
            hold_vld_d  = 1'b1;
        end

        if (pop | issue | ~hold_vld_q)
            idle_cnt_d = '0;
        else if (fifo_empty && idle_cnt_q != IDLE_MAX)
            idle_cnt_d = idle_cnt_q + IW'(1);

        if (issue & close)
            flush_pend_d = 1'b0;
        else if (flush)
            flush_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q   <= 1'b0;
            hold_data_q  <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            hold_vld_q   <= hold_vld_d;
            hold_data_q  <= hold_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            beat_cnt_q   <= beat_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign fifo_rden = pop;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign beat_cnt  = beat_cnt_q;
    assign busy      = hold_vld_q | m_valid_q;

endmodule

// File: tb/tb_fifo_burst_framer.sv
// Bench for fifo_burst_framer: a small FWFT FIFO model feeds the DUT and a
// scoreboard of {last,data} is checked at every stream handshake.
module tb_fifo_burst_framer;

    localparam int DW = 16;
    localparam int BL = 8;
    localparam int TO = 32;
    localparam int CW = $clog2(BL + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rden;
    logic          flush = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic [CW-1:0] beat_cnt;
    logic          busy;

    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    always #5 clk = ~clk;

    fifo_burst_framer #(.DW(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rden (fifo_rden),
        .flush     (flush),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .beat_cnt  (beat_cnt),
        .busy      (busy)
    );

    // FWFT FIFO model with a registered occupancy count, reset by the same rst_n.
    logic [DW-1:0] mem [0:63];
    logic [5:0]    wp, rp;
    logic [6:0]    cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= wp + 6'd1;
            end
            if (fifo_rden) rp <= rp + 6'd1;
            cnt <= cnt + {6'd0, wr_en} - {6'd0, fifo_rden};
        end
    end

    assign fifo_empty = (cnt == 7'd0);
    assign fifo_dout  = mem[rp];

    int            n_tests = 0;
    int            n_fail = 0;
    logic [DW:0]   sb [$];
    int            hs_count = 0;
    int            cyc = 0;
    int            last_hs_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples mid-cycle after the drivers have settled.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [DW:0]   exp_beat;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, m_valid}, 32'd1);
                chk("stall_data", {16'd0, m_data}, {16'd0, prev_data});
                chk("stall_last", {31'd0, m_last}, {31'd0, prev_last});
            end
            if (fifo_empty) chk("rden_when_empty", {31'd0, fifo_rden}, 32'd0);
            if (m_valid && m_ready) begin
                hs_count++;
                last_hs_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {16'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_beat = sb.pop_front();
                    chk("beat_data", {16'd0, m_data}, {16'd0, exp_beat[DW-1:0]});
                    chk("beat_last", {31'd0, m_last}, {31'd0, exp_beat[DW]});
                end
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic wr(input logic [DW-1:0] d, input logic l, input bit track);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        if (track) sb.push_back({l, d});
    endtask

    task automatic wr_stop();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   t0;
        int   hs0;
        int   n;
        logic [3:0] pat;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_m_last", {31'd0, m_last}, 0);
        chk("rst_m_data", {16'd0, m_data}, 0);
        chk("rst_beat_cnt", {28'd0, beat_cnt}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rden", {31'd0, fifo_rden}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Burst framing: 16 preloaded words, last on 8th and 16th.
        m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) wr(DW'(i), (i % 8) == 0, 1'b1);
        wr_stop();
        repeat (3) @(negedge clk);
        hs0 = hs_count;
        m_ready = 1'b1;
        repeat (16) @(negedge clk);
        #1;
        chk("burst_consecutive", hs_count - hs0, 16);
        drain(50);
        chk("burst_beat_cnt", {28'd0, beat_cnt}, 0);
        chk("burst_busy_idle", {31'd0, busy}, 0);

        // Idle timeout closes a 3-word partial burst 32 cycles after the FIFO empties.
        wr(16'h0001, 1'b0, 1'b1);
        wr(16'h0002, 1'b0, 1'b1);
        wr(16'h0003, 1'b1, 1'b1);
        wr_stop();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_empty && n < 20);
        chk("timeout_empty_seen", {31'd0, fifo_empty}, 1);
        t0 = cyc;
        drain(100);
        chk("timeout_latency", last_hs_cyc - t0, 32);
        chk("timeout_beat_cnt", {28'd0, beat_cnt}, 0);

        // Backpressure with ready pattern 1,0,0,1.
        for (int i = 1; i <= 10; i++) wr(16'h0300 + DW'(i), (i == 8) || (i == 10), 1'b1);
        wr_stop();
        pat = 4'b1001;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            m_ready = pat[3 - (n % 4)];
            n++;
        end
        m_ready = 1'b1;
        drain(10);

        // Flush with the FIFO non-empty: the held 2nd word closes the burst.
        m_ready = 1'b0;
        wr(16'h0401, 1'b0, 1'b1);
        wr(16'h0402, 1'b1, 1'b1);
        for (int i = 3; i <= 7; i++) wr(16'h0400 + DW'(i), i == 7, 1'b1);
        wr_stop();
        repeat (3) @(negedge clk);
        @(negedge clk) flush = 1'b1;
        @(negedge clk) flush = 1'b0;
        repeat (2) @(negedge clk);
        m_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_valid && m_data == 16'h0402) && n < 20);
        chk("flush_word2_seen", {16'd0, m_data}, 32'h0402);
        chk("flush_beat_cnt", {28'd0, beat_cnt}, 0);
        drain(100);

        // Timeout while the output is stalled.
        m_ready = 1'b0;
        wr(16'h0501, 1'b0, 1'b1);
        wr(16'h0502, 1'b1, 1'b1);
        wr_stop();
        repeat (50) @(negedge clk);
        chk("stall_head", {16'd0, m_data}, 32'h0501);
        m_ready = 1'b1;
        drain(20);

        // Timeout pending under stall, then a new word lapses it.
        m_ready = 1'b0;
        wr(16'h0503, 1'b0, 1'b1);
        wr(16'h0504, 1'b0, 1'b1);
        wr_stop();
        repeat (50) @(negedge clk);
        wr(16'h0505, 1'b1, 1'b1);
        wr_stop();
        repeat (3) @(negedge clk);
        m_ready = 1'b1;
        drain(100);

        // Asynchronous reset mid-burst.
        m_ready = 1'b0;
        wr(16'h0601, 1'b0, 1'b0);
        wr(16'h0602, 1'b0, 1'b0);
        wr(16'h0603, 1'b0, 1'b0);
        wr_stop();
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", {31'd0, m_valid}, 1);
        chk("pre_rst_beat_cnt", {28'd0, beat_cnt}, 1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, m_valid}, 0);
        chk("mid_rst_last", {31'd0, m_last}, 0);
        chk("mid_rst_data", {16'd0, m_data}, 0);
        chk("mid_rst_beat_cnt", {28'd0, beat_cnt}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_rden", {31'd0, fifo_rden}, 0);
        end
        rst_n = 1'b1;
        m_ready = 1'b1;
        wr(16'h0701, 1'b0, 1'b1);
        wr(16'h0702, 1'b1, 1'b1);
        wr_stop();
        drain(100);
        chk("final_busy", {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_burst_framer.md
Name: fifo_burst_framer

Overview:
- Downstream consumer of the team's synchronous FIFO. Drains the FIFO's first-word-fall-through read port and turns it into a valid/ready stream.
- Groups words into bursts of up to BURST_LEN beats and flags the last beat of each burst.
- Holds one word back so that `last` is known before a word is presented. This lets a burst close early on FIFO idle timeout or on a flush request.
- Sits between the FIFO and the DMA/packet egress logic.

Parameters:
- DW, 16, data width; must match the FIFO's DW.
- BURST_LEN, 8, maximum beats per burst; must be ≥2.
- TIMEOUT, 32, consecutive cycles of (hold_vld & fifo_empty) after which a partial burst is closed; must be ≥1.
- CW, $clog2(BURST_LEN+1), width of the beat counter output.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- fifo_dout, in, DW, FIFO head word; valid whenever fifo_empty=0.
- fifo_empty, in, 1, FIFO empty flag (registered in the FIFO).
- fifo_rden, out, 1, FIFO pop strobe; combinational.
- flush, in, 1, single-cycle request to close the current burst at the held word.
- m_data, out, DW, stream data.
- m_valid, out, 1, stream valid.
- m_last, out, 1, last beat of burst.
- m_ready, in, 1, stream ready from the sink.
- beat_cnt, out, CW, beats already issued in the current burst.
- busy, out, 1, asserted when hold_vld | m_valid.

Behaviour:
- Reset (async): m_valid=0, m_last=0, m_data=0, hold_vld=0, hold_data=0, beat_cnt=0, idle_cnt=0, flush_pend=0. fifo_rden=0 while reset is asserted.
- Internal signals:
  - adv = ~m_valid | m_ready (output register can load this cycle).
  - close = (beat_cnt==BURST_LEN-1) | flush | flush_pend | (idle_cnt==TIMEOUT-1 & fifo_empty).
  - issue = hold_vld & adv & (~fifo_empty | close).
- Pop rule: fifo_rden = ~fifo_empty & (~hold_vld | issue). Never assert fifo_rden when fifo_empty=1.
- On fifo_rden: hold_data <= fifo_dout; hold_vld <= 1.
- On issue:
  - m_data <= hold_data; m_valid <= 1; m_last <= close.
  - hold_vld <= fifo_rden (refilled in the same cycle if a word was popped).
- On m_valid & m_ready & ~issue: m_valid <= 0.
- m_data and m_last stay stable while m_valid & ~m_ready.
- beat_cnt:
  - On issue with close: beat_cnt <= 0.
  - On issue without close: beat_cnt <= beat_cnt+1.
  - A burst never exceeds BURST_LEN beats.
- idle_cnt:
  - Increments while hold_vld & fifo_empty & ~issue, saturating at TIMEOUT-1.
  - Clears on any fifo_rden, on issue, or when hold_vld=0.
- Timeout while blocked: if idle_cnt reaches TIMEOUT-1 while adv=0, the close stays pending. The held word issues with last=1 on the first adv cycle, provided the FIFO is still empty.
- Word arrives first: if a word appears in the FIFO before adv, the close condition for the timeout lapses and the held word issues as a normal beat.
- flush:
  - flush with hold_vld=0: sets flush_pend; the next held word issues with last=1.
  - flush with hold_vld=1: sets flush_pend if the hold cannot issue this cycle.
  - flush_pend clears on any issue with close.
  - Multiple flushes before an issue collapse into one.
- Latency: a word popped on edge N is held at N+1. Earliest m_valid is edge N+2 (when the next word or a close is present).
- Throughput: 1 beat/cycle when the FIFO stays non-empty and m_ready=1.
- Data order is preserved; no word is dropped or duplicated.
- Mid-operation reset: all state is discarded, including the held and output words. The FIFO is reset by the same rst_n.

Test Plan:
- Burst framing: preload 16 words 0x0001..0x0010, m_ready=1, BURST_LEN=8 → 16 beats on consecutive cycles; m_last=1 on 0x0008 and 0x0010 only. (0x0010 closes via beat_cnt==7.)
- Idle timeout: write 3 words then stop, TIMEOUT=32 → 0x0001 and 0x0002 issue with last=0. 0x0003 issues with last=1 exactly 32 cycles after fifo_empty rises with the word held. beat_cnt returns to 0.
- Backpressure: stream 10 words, m_ready toggling 1,0,0,1 repeating → no loss or duplication. m_data and m_last stay stable during every m_ready=0 cycle. fifo_rden is never asserted with fifo_empty=1.
- Flush: after 2 words, pulse flush while the FIFO is non-empty with 5 more words → the held 2nd word issues with m_last=1. The next burst starts with the 3rd word and beat_cnt=0.
- Timeout under stall: hold a word with m_ready=0 for 50 cycles and the FIFO empty → single beat with m_last=1 once m_ready=1. Then write 1 word before the next adv → that word issues as a normal beat.
- Reset: assert rst_n=0 mid-burst with m_valid=1 → m_valid, m_last, beat_cnt and busy read 0 immediately (asynchronous). fifo_rden stays 0 until release and the FIFO refills.
